// File: rtl/t_ff_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : t_ff_counter_sequencer
//  Description : Sequences a bank of WIDTH toggle flip-flops as a modulo
//                up/down counter.
//
//                The bank (Count_Out) changes only through the toggle vector:
//                Count_Out <= Count_Out ^ T_Vec_Out.
//
//                A five-state FSM handles the control sequence:
//                IDLE -> LOAD -> RUN <-> PAUSE, and RUN -> DONE (one-shot).
//
//  Ports       :
//    Clk_In      - clock, rising edge
//    Reset_In    - asynchronous active-low reset
//    Start_In    - start from IDLE/DONE, resume from PAUSE
//    Stop_In     - pause from RUN, abort from PAUSE
//    Dir_In      - 1 = up, 0 = down (sampled on start)
//    One_Shot_In - stop after the first wrap (sampled on start)
//    Limit_In    - terminal value (sampled on start)
//    Count_Out   - T flip-flop bank state
//    T_Vec_Out   - toggle vector applied at the next edge (combinational)
//    Busy_Out    - high in LOAD, RUN, PAUSE
//    Tc_Out      - one-cycle pulse while the bank shows a wrapped value
//    Done_Out    - high while in DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module t_ff_counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Start_In,
    input  logic             Stop_In,
    input  logic             Dir_In,
    input  logic             One_Shot_In,
    input  logic [WIDTH-1:0] Limit_In,
    output logic [WIDTH-1:0] Count_Out,
    output logic [WIDTH-1:0] T_Vec_Out,
    output logic             Busy_Out,
    output logic             Tc_Out,
    output logic             Done_Out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic             r_dir;
    logic             r_one_shot;
    logic             r_tc;

    logic [WIDTH-1:0] w_t_vec;
    logic [WIDTH-1:0] w_up_step;
    logic [WIDTH-1:0] w_dn_step;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_init;
    logic             w_wrap;
    logic             w_sample;
    logic             w_tc_set;

    // Ripple toggle pattern of a binary counter: bit i toggles when all
    // lower bits are 1 (up) or all lower bits are 0 (down).
    assign w_up_step[0] = 1'b1;
    assign w_dn_step[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_step
        assign w_up_step[i] = &r_count[i-1:0];
        assign w_dn_step[i] = ~|r_count[i-1:0];
    end

    // Wrap: up reaches the limit and toggles every set bit to land on 0;
    // down reaches 0 and toggles the limit bits to land on the limit.
    assign w_wrap = r_dir ? (r_count == r_limit) : (r_count == '0);
    assign w_step = w_wrap ? (r_dir ? r_count : r_limit)
                           : (r_dir ? w_up_step : w_dn_step);
    assign w_init = r_dir ? '0 : r_limit;

    always_comb begin
        w_state_nxt = r_state;
        w_t_vec     = '0;
        w_sample    = 1'b0;
        w_tc_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start_In) begin
                    w_state_nxt = ST_LOAD;
                    w_sample    = 1'b1;
                end
            end
            ST_LOAD: begin
                // Toggle exactly the bits that differ from the start value.
                w_t_vec     = r_count ^ w_init;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (Stop_In) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_t_vec  = w_step;
                    w_tc_set = w_wrap;
                    if (w_wrap && r_one_shot) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (Stop_In) begin
                    w_state_nxt = ST_IDLE;
                end else if (Start_In) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (Start_In) begin
                    w_state_nxt = ST_LOAD;
                    w_sample    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_limit    <= '0;
            r_dir      <= 1'b0;
            r_one_shot <= 1'b0;
            r_tc       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= r_count ^ w_t_vec;
            r_tc    <= w_tc_set;
            if (w_sample) begin
                r_limit    <= Limit_In;
                r_dir      <= Dir_In;
                r_one_shot <= One_Shot_In;
            end
        end
    end

    assign Count_Out = r_count;
    assign T_Vec_Out = w_t_vec;
    assign Busy_Out  = (r_state == ST_LOAD) || (r_state == ST_RUN) ||
                       (r_state == ST_PAUSE);
    assign Tc_Out    = r_tc;
    assign Done_Out  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_t_ff_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t_ff_counter_sequencer
//  Description : Directed bench for t_ff_counter_sequencer (WIDTH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t_ff_counter_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       dir;
    logic       one_shot;
    logic [3:0] limit;
    logic [3:0] count;
    logic [3:0] t_vec;
    logic       busy;
    logic       tc;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;

    t_ff_counter_sequencer #(.WIDTH(4)) dut (
        .Clk_In      (clk),
        .Reset_In    (rst_n),
        .Start_In    (start),
        .Stop_In     (stop),
        .Dir_In      (dir),
        .One_Shot_In (one_shot),
        .Limit_In    (limit),
        .Count_Out   (count),
        .T_Vec_Out   (t_vec),
        .Busy_Out    (busy),
        .Tc_Out      (tc),
        .Done_Out    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check count plus status flags in one call.
    task automatic check_st(input string tag, input logic [3:0] e_cnt,
                            input logic e_busy, input logic e_tc, input logic e_done);
        check({tag, "/count"}, {12'd0, count}, {12'd0, e_cnt});
        check({tag, "/busy"},  {15'd0, busy},  {15'd0, e_busy});
        check({tag, "/tc"},    {15'd0, tc},    {15'd0, e_tc});
        check({tag, "/done"},  {15'd0, done},  {15'd0, e_done});
    endtask

    task automatic check_t(input string tag, input logic [3:0] e_t);
        check({tag, "/tvec"}, {12'd0, t_vec}, {12'd0, e_t});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0;
        one_shot = 1'b0; limit = 4'd0;

        // ---------------- reset ----------------
        tick(); tick();
        check_st("rst", 4'd0, 1'b0, 1'b0, 1'b0);
        check_t("rst", 4'd0);
        rst_n = 1'b1;
        tick();
        check_st("idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // ---------------- up free-run, limit 5 ----------------
        start = 1'b1; dir = 1'b1; one_shot = 1'b0; limit = 4'd5;
        tick();                                   // LOAD
        start = 1'b0;
        check_st("up_load", 4'd0, 1'b1, 1'b0, 1'b0);
        check_t("up_load", 4'd0);
        limit = 4'd2;                              // must not affect the run
        tick();                                   // RUN, count 0
        check_st("up_c0", 4'd0, 1'b1, 1'b0, 1'b0);
        check_t("up_c0", 4'b0001);
        tick(); check_st("up_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); check_st("up_c2", 4'd2, 1'b1, 1'b0, 1'b0);
        tick(); check_st("up_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        check_t("up_c3", 4'b0111);
        tick(); check_st("up_c4", 4'd4, 1'b1, 1'b0, 1'b0);
        tick(); check_st("up_c5", 4'd5, 1'b1, 1'b0, 1'b0);
        check_t("up_c5", 4'b0101);
        tick(); check_st("up_wrap", 4'd0, 1'b1, 1'b1, 1'b0);
        tick(); check_st("up_c1b", 4'd1, 1'b1, 1'b0, 1'b0);

        // stop -> PAUSE, stop again -> IDLE (abort, count held)
        stop = 1'b1; #1;
        check_t("up_stop", 4'd0);
        tick(); check_st("up_pause", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); check_st("up_abort", 4'd1, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;

        // ---------------- down one-shot, limit 9 ----------------
        start = 1'b1; dir = 1'b0; one_shot = 1'b1; limit = 4'd9;
        tick();                                   // LOAD
        start = 1'b0;
        check_t("dn_load", 4'b1000);             // 1 ^ 9
        tick(); check_st("dn_c9", 4'd9, 1'b1, 1'b0, 1'b0);
        tick(); check_st("dn_c8", 4'd8, 1'b1, 1'b0, 1'b0);
        check_t("dn_c8", 4'b1111);
        tick(); check_st("dn_c7", 4'd7, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick(); tick(); tick();
        check_st("dn_c2", 4'd2, 1'b1, 1'b0, 1'b0);
        tick(); check_st("dn_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); check_st("dn_c0", 4'd0, 1'b1, 1'b0, 1'b0);
        check_t("dn_c0", 4'd9);
        tick(); check_st("dn_done", 4'd9, 1'b0, 1'b1, 1'b1);
        stop = 1'b1;                              // ignored in DONE
        tick(); check_st("dn_hold", 4'd9, 1'b0, 1'b0, 1'b1);
        stop = 1'b0;

        // ---------------- restart from DONE: up, limit 15 ----------------
        start = 1'b1; dir = 1'b1; one_shot = 1'b0; limit = 4'd15;
        tick();                                   // LOAD
        start = 1'b0;
        check_st("pr_load", 4'd9, 1'b1, 1'b0, 1'b0);
        check_t("pr_load", 4'd9);
        tick(); check_st("pr_c0", 4'd0, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick(); tick(); tick(); tick();
        check_st("pr_c6", 4'd6, 1'b1, 1'b0, 1'b0);
        stop = 1'b1; start = 1'b1; #1;            // stop wins over start
        check_t("pr_stop", 4'd0);
        tick(); stop = 1'b0; start = 1'b0;
        check_st("pr_p1", 4'd6, 1'b1, 1'b0, 1'b0);
        check_t("pr_p1", 4'd0);
        tick(); check_st("pr_p2", 4'd6, 1'b1, 1'b0, 1'b0);
        tick(); check_st("pr_p3", 4'd6, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick(); start = 1'b0;                     // back to RUN, no reload
        check_st("pr_res", 4'd6, 1'b1, 1'b0, 1'b0);
        tick(); check_st("pr_c7", 4'd7, 1'b1, 1'b0, 1'b0);
        tick(); check_st("pr_c8", 4'd8, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        tick(); check_st("pr_pause2", 4'd8, 1'b1, 1'b0, 1'b0);
        start = 1'b1;                             // stop + start in PAUSE
        tick(); stop = 1'b0; start = 1'b0;
        check_st("pr_abort", 4'd8, 1'b0, 1'b0, 1'b0);
        tick(); check_st("pr_idle", 4'd8, 1'b0, 1'b0, 1'b0);

        // ---------------- limit 0, up, free-run ----------------
        start = 1'b1; dir = 1'b1; limit = 4'd0;
        tick(); start = 1'b0;
        check_t("z_load", 4'd8);
        tick(); check_st("z_r1", 4'd0, 1'b1, 1'b0, 1'b0);
        check_t("z_r1", 4'd0);
        tick(); check_st("z_r2", 4'd0, 1'b1, 1'b1, 1'b0);
        tick(); check_st("z_r3", 4'd0, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        tick(); tick(); stop = 1'b0;
        check_st("z_idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // ---------------- async reset mid-run ----------------
        start = 1'b1; dir = 1'b1; limit = 4'd15;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check_st("ar_c4", 4'd4, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_st("ar_rst", 4'd0, 1'b0, 1'b0, 1'b0);
        check_t("ar_rst", 4'd0);
        tick();
        rst_n = 1'b1;
        start = 1'b1; dir = 1'b0; one_shot = 1'b0; limit = 4'd3;
        tick(); start = 1'b0;
        check_t("ar_load", 4'd3);
        tick(); check_st("ar_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        tick(); check_st("ar_c2", 4'd2, 1'b1, 1'b0, 1'b0);
        tick(); check_st("ar_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); check_st("ar_c0", 4'd0, 1'b1, 1'b0, 1'b0);
        tick(); check_st("ar_wrap", 4'd3, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
